// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI master.
package spi_pkg;

    localparam int unsigned SPI_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_GAP   = 3'd6
    } spi_state_e;

    // States whose duration is set by the phase timer.
    function automatic logic is_timed(input spi_state_e st);
        case (st)
            ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD, ST_GAP: is_timed = 1'b1;
            default:                                    is_timed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// CLK_DIV down-counter; reloads on every state change and flags the
// last (phase_done) and second-to-last (phase_next) cycle of a timed state.
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic timed,
    output logic phase_done,
    output logic phase_next
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_d;
    logic [7:0] cnt_q;

    // Next count: reload on state change, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_done = timed && (cnt_q == 8'd0);
    assign phase_next = timed && (cnt_q == 8'd1);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: byte stream in, MSB first, CS_n held across a
// multi-byte transaction until the byte marked tx_last completes.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       CS_n,
    output logic       SCLK,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

    spi_state_e state_d, state_q;
    logic [2:0] bit_d, bit_q;
    logic [7:0] tx_byte_d, tx_byte_q;
    logic       last_d, last_q;
    logic [6:0] rx_sh_d, rx_sh_q;
    logic [7:0] rx_data_d, rx_data_q;
    logic       rx_valid_d, rx_valid_q;
    logic       tx_ready_d, tx_ready_q;
    logic       cs_n_d, cs_n_q;
    logic       sclk_d, sclk_q;
    logic       mosi_d, mosi_q;
    logic       busy_d, busy_q;

    logic       accept_s;
    logic       load_s;
    logic       timed_s;
    logic       phase_done_s;
    logic       phase_next_s;
    logic       ready_near_s;
    logic [2:0] nxt_bit_s;
    logic [7:0] rx_sample_s;

    assign accept_s    = tx_valid && tx_ready_q;
    assign nxt_bit_s   = bit_q + 3'd1;
    assign rx_sample_s = {rx_sh_q, MISO};
    assign load_s      = (state_d != state_q);
    assign timed_s     = is_timed(state_q);

    spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_s),
        .timed      (timed_s),
        .phase_done (phase_done_s),
        .phase_next (phase_next_s)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        tx_byte_d  = tx_byte_q;
        last_d     = last_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        mosi_d     = mosi_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_SETUP;
                    tx_byte_d = tx_data;
                    last_d    = tx_last;
                    bit_d     = 3'd0;
                    mosi_d    = tx_data[7];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (phase_done_s) begin
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_HIGH: begin
                if (phase_done_s) begin
                    rx_sh_d = rx_sample_s[6:0];
                    if (bit_q == LAST_BIT) begin
                        // Byte boundary: publish rx and chain, wait or close.
                        rx_data_d  = rx_sample_s;
                        rx_valid_d = 1'b1;
                        bit_d      = 3'd0;
                        if (last_q) begin
                            state_d = ST_HOLD;
                        end else if (accept_s) begin
                            state_d   = ST_LOW;
                            tx_byte_d = tx_data;
                            last_d    = tx_last;
                            mosi_d    = tx_data[7];
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        state_d = ST_LOW;
                        bit_d   = nxt_bit_s;
                        mosi_d  = tx_byte_q[3'd7 - nxt_bit_s];
                    end
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (phase_done_s) begin
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_WAIT: begin
                if (accept_s) begin
                    state_d   = ST_LOW;
                    tx_byte_d = tx_data;
                    last_d    = tx_last;
                    mosi_d    = tx_data[7];
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (phase_done_s) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (phase_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the cycle after this edge, derived from state_d.
    always_comb begin
        ready_near_s = (state_q == ST_HIGH) && phase_next_s &&
                       (bit_q == LAST_BIT) && !last_q;
        tx_ready_d   = (state_d == ST_IDLE) || (state_d == ST_WAIT) || ready_near_s;
        cs_n_d       = (state_d == ST_IDLE) || (state_d == ST_GAP);
        sclk_d       = (state_d == ST_HIGH);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_q      <= 3'd0;
            tx_byte_q  <= 8'h00;
            last_q     <= 1'b0;
            rx_sh_q    <= 7'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            tx_byte_q  <= tx_byte_d;
            last_q     <= last_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            mosi_q     <= mosi_d;
        end
    end

    // Registered interface outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_ready_q <= tx_ready_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign CS_n     = cs_n_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with CLK_DIV=4 and a simple slave model.
module tb_spi_master;

    localparam int CLK_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       CS_n;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;

    int          errors = 0;
    int          checks = 0;
    int          rises  = 0;
    logic [15:0] mosi_cap   = 16'h0000;
    logic        sclk_prev  = 1'b0;
    logic        loop_en    = 1'b0;
    logic [7:0]  slave_byte = 8'h00;

    spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .CS_n     (CS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge; track SCLK rises, capture MOSI, drive MISO.
    task automatic tick();
        int idx;
        @(negedge clk);
        if (SCLK === 1'b1 && sclk_prev !== 1'b1) begin
            rises++;
            mosi_cap = {mosi_cap[14:0], MOSI};
        end
        sclk_prev = SCLK;
        idx = (rises == 0) ? 0 : ((rises - 1) % 8);
        MISO = loop_en ? MOSI : slave_byte[7 - idx];
    endtask

    task automatic test_reset();
        rst_n = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0; MISO = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (CS_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", CS_n); end
        checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
        checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        tick(); tick();
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_held_tx_ready: got %b want 0", tx_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL release_no_edge_tx_ready: got %b want 0", tx_ready); end
        tick();
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL release_tx_ready: got %b want 1", tx_ready); end
        checks++; if (CS_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL release_idle: got cs_n=%b busy=%b want 1/0", CS_n, busy); end
    endtask

    task automatic test_single_byte();
        int cs_bad = 0; int rv_cnt = 0; int rv_cyc = -1; int idle_cyc = -1;
        logic [7:0] rv_data = 8'h00;
        loop_en = 1'b0; slave_byte = 8'h3C; rises = 0; mosi_cap = 16'h0000;
        tx_data = 8'hA5; tx_last = 1'b1; tx_valid = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (c == 1) begin tx_valid = 1'b0; tx_data = 8'hFF; tx_last = 1'b0; end
            if (c <= 68 && CS_n !== 1'b0) cs_bad++;
            if (c > 68 && CS_n !== 1'b1) cs_bad++;
            if (rx_valid === 1'b1) begin rv_cnt++; rv_cyc = c; rv_data = rx_data; end
            if (idle_cyc < 0 && busy === 1'b0) idle_cyc = c;
        end
        checks++; if (cs_bad != 0) begin errors++; $display("FAIL single_cs_window: got %0d bad cycles want 0", cs_bad); end
        checks++; if (rises != 8) begin errors++; $display("FAIL single_edges: got %0d want 8", rises); end
        checks++; if (mosi_cap[7:0] !== 8'hA5) begin errors++; $display("FAIL single_mosi: got %h want a5", mosi_cap[7:0]); end
        checks++; if (rv_cnt != 1) begin errors++; $display("FAIL single_rx_count: got %0d want 1", rv_cnt); end
        checks++; if (rv_cyc != 65) begin errors++; $display("FAIL single_rx_cycle: got %0d want 65", rv_cyc); end
        checks++; if (rv_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h want 3c", rv_data); end
        checks++; if (idle_cyc != 73) begin errors++; $display("FAIL single_idle_cycle: got %0d want 73", idle_cyc); end
    endtask

    task automatic test_burst();
        int acc2 = -1; int cs_bad = 0; int rv_cnt = 0; int rv1 = -1; int rv2 = -1;
        logic [7:0] rd1 = 8'h00;
        loop_en = 1'b0; slave_byte = 8'hC3; rises = 0; mosi_cap = 16'h0000;
        tx_data = 8'h12; tx_last = 1'b0; tx_valid = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            tick();
            if (c == 1) begin tx_data = 8'h34; tx_last = 1'b1; end
            if (acc2 >= 0) tx_valid = 1'b0;
            else if (tx_valid === 1'b1 && tx_ready === 1'b1) acc2 = c;
            if (c <= 132 && CS_n !== 1'b0) cs_bad++;
            if (c > 132 && c <= 136 && CS_n !== 1'b1) cs_bad++;
            if (rx_valid === 1'b1) begin
                rv_cnt++;
                if (rv1 < 0) begin rv1 = c; rd1 = rx_data; end
                else if (rv2 < 0) rv2 = c;
            end
        end
        checks++; if (acc2 != 64) begin errors++; $display("FAIL burst_accept_cycle: got %0d want 64", acc2); end
        checks++; if (cs_bad != 0) begin errors++; $display("FAIL burst_cs_window: got %0d bad cycles want 0", cs_bad); end
        checks++; if (rises != 16) begin errors++; $display("FAIL burst_edges: got %0d want 16", rises); end
        checks++; if (mosi_cap !== 16'h1234) begin errors++; $display("FAIL burst_mosi: got %h want 1234", mosi_cap); end
        checks++; if (rv_cnt != 2) begin errors++; $display("FAIL burst_rx_count: got %0d want 2", rv_cnt); end
        checks++; if (rv1 != 65 || rv2 != 129) begin errors++; $display("FAIL burst_rx_cycles: got %0d/%0d want 65/129", rv1, rv2); end
        checks++; if (rd1 !== 8'hC3) begin errors++; $display("FAIL burst_rx_data: got %h want c3", rd1); end
    endtask

    task automatic test_stall();
        int wait_bad = 0; int rises_wait = -1; int rv2 = -1; int rv_cnt = 0;
        logic [7:0] rd1 = 8'h00; logic [7:0] rd2 = 8'h00;
        loop_en = 1'b1; rises = 0; mosi_cap = 16'h0000;
        tx_data = 8'h55; tx_last = 1'b0; tx_valid = 1'b1;
        for (int c = 1; c <= 165; c++) begin
            tick();
            if (c == 1) begin tx_valid = 1'b0; tx_data = 8'h00; end
            if (c >= 65 && c <= 85 &&
                (CS_n !== 1'b0 || SCLK !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1)) wait_bad++;
            if (c == 85) begin
                rises_wait = rises;
                tx_valid = 1'b1; tx_data = 8'hAA; tx_last = 1'b1;
            end
            if (c == 86) tx_valid = 1'b0;
            if (rx_valid === 1'b1) begin
                rv_cnt++;
                if (rv_cnt == 1) rd1 = rx_data;
                else begin rv2 = c; rd2 = rx_data; end
            end
        end
        checks++; if (wait_bad != 0) begin errors++; $display("FAIL stall_wait_state: got %0d bad cycles want 0", wait_bad); end
        checks++; if (rises_wait != 8) begin errors++; $display("FAIL stall_edges_in_wait: got %0d want 8", rises_wait); end
        checks++; if (rises != 16) begin errors++; $display("FAIL stall_edges_total: got %0d want 16", rises); end
        checks++; if (mosi_cap !== 16'h55AA) begin errors++; $display("FAIL stall_mosi: got %h want 55aa", mosi_cap); end
        checks++; if (rv2 != 150 || rd1 !== 8'h55 || rd2 !== 8'hAA) begin errors++; $display("FAIL stall_rx: got cyc=%0d %h/%h want 150 55/aa", rv2, rd1, rd2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int guard = 0; int rv_cnt = 0; int got_rv = 0;
        logic [7:0] rd = 8'h00;
        loop_en = 1'b0; slave_byte = 8'hFF; rises = 0; mosi_cap = 16'h0000;
        tx_data = 8'hF0; tx_last = 1'b1; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        while (rises < 3 && guard < 200) begin tick(); guard++; end
        checks++; if (rises != 3) begin errors++; $display("FAIL midreset_reach_edge3: got %0d edges want 3", rises); end
        checks++; if (SCLK !== 1'b1 || CS_n !== 1'b0) begin errors++; $display("FAIL midreset_pre: got sclk=%b cs_n=%b want 1/0", SCLK, CS_n); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (CS_n !== 1'b1 || SCLK !== 1'b0) begin errors++; $display("FAIL midreset_async: got cs_n=%b sclk=%b want 1/0", CS_n, SCLK); end
        checks++; if (busy !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL midreset_flags: got busy=%b ready=%b want 0/0", busy, tx_ready); end
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (rx_valid === 1'b1) rv_cnt++;
        end
        checks++; if (rv_cnt != 0 || rx_data !== 8'h00) begin errors++; $display("FAIL midreset_silent: got %0d pulses data=%h want 0/00", rv_cnt, rx_data); end
        loop_en = 1'b1; rises = 0; mosi_cap = 16'h0000;
        tx_data = 8'h96; tx_last = 1'b1; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int c = 0; c < 100 && got_rv == 0; c++) begin
            tick();
            if (rx_valid === 1'b1) begin got_rv = 1; rd = rx_data; end
        end
        checks++; if (got_rv != 1 || rd !== 8'h96) begin errors++; $display("FAIL midreset_next_byte: got valid=%0d data=%h want 1/96", got_rv, rd); end
        checks++; if (mosi_cap[7:0] !== 8'h96 || rises != 8) begin errors++; $display("FAIL midreset_next_mosi: got %h edges=%0d want 96/8", mosi_cap[7:0], rises); end
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midreset_return_idle: got ready=%b want 1", tx_ready); end
    endtask

    task automatic test_loopback();
        logic [7:0] vals [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
        int guard; int got_rv;
        logic [7:0] rd;
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (tx_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
            tx_data = vals[i]; tx_last = 1'b1; tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            got_rv = 0; rd = 8'h00;
            for (int c = 0; c < 100 && got_rv == 0; c++) begin
                tick();
                if (rx_valid === 1'b1) begin got_rv = 1; rd = rx_data; end
            end
            checks++;
            if (got_rv != 1 || rd !== vals[i]) begin
                errors++;
                $display("FAIL loopback_%0d: got valid=%0d data=%h want 1/%h", i, got_rv, rd, vals[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst();
        test_stall();
        test_reset_mid();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
